// File: rtl/rec_if.sv
// Valid/ready handshake bundle carrying one parsed
// trace access record from the parser FIFO head.
interface rec_if #(
    parameter int ADDR_W = 32
);
    logic              valid;
    logic              ready;
    logic              we;
    logic [ADDR_W-1:0] addr;

    modport master (
        output valid,
        output we,
        output addr,
        input  ready
    );

    modport slave (
        input  valid,
        input  we,
        input  addr,
        output ready
    );
endinterface

// File: rtl/trace_record_parser.sv
// Parses "<op> <hexaddr>\n" text lines into access records
// and queues them in a first-word-fall-through FIFO.
module trace_record_parser #(
    parameter int ADDR_W  = 32,
    parameter int FIFO_AW = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic [7:0]  i_byte,
    rec_if.master       m_rec,
    output logic        o_overflow,
    output logic [31:0] o_rec_count,
    output logic [15:0] o_err_count
);
    localparam int MAXD  = ADDR_W / 4;
    localparam int ND_W  = $clog2(MAXD + 1);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [ND_W-1:0] ND_MAX = ND_W'(MAXD);

    typedef enum logic [2:0] {
        S_OP, S_GAP, S_ADDR, S_TAIL, S_SKIP
    } state_t;

    state_t              r_state;
    logic                r_op;
    logic [ADDR_W-1:0]   r_acc;
    logic [ND_W-1:0]     r_ndig;
    logic [15:0]         r_err_cnt;
    logic [31:0]         r_rec_cnt;
    logic                r_overflow;
    logic [FIFO_AW:0]    r_wptr;
    logic [FIFO_AW:0]    r_rptr;
    logic [ADDR_W:0]     r_mem [DEPTH];

    logic       w_act, w_ws, w_nl, w_op_r, w_op_w;
    logic       w_is_hex, w_x0, w_push, w_err;
    logic       w_empty, w_full, w_pop, w_accept;
    logic [3:0] w_hex;
    logic [ADDR_W:0] w_head;

    assign w_act  = i_en && (i_byte != 8'h0D);
    assign w_ws   = (i_byte == 8'h20) || (i_byte == 8'h09);
    assign w_nl   = (i_byte == 8'h0A);
    assign w_op_r = (i_byte == 8'h52) || (i_byte == 8'h72)
                 || (i_byte == 8'h30);
    assign w_op_w = (i_byte == 8'h57) || (i_byte == 8'h77)
                 || (i_byte == 8'h31);
    // "0x" prefix: only legal right after a single leading zero
    assign w_x0   = ((i_byte == 8'h78) || (i_byte == 8'h58))
                 && (r_ndig == ND_W'(1)) && (r_acc == '0);

    always_comb begin
        w_is_hex = 1'b1;
        w_hex    = 4'd0;
        unique case (1'b1)
            (i_byte >= 8'h30 && i_byte <= 8'h39):
                w_hex = i_byte[3:0];
            (i_byte >= 8'h61 && i_byte <= 8'h66),
            (i_byte >= 8'h41 && i_byte <= 8'h46):
                w_hex = i_byte[3:0] + 4'd9;
            default:
                w_is_hex = 1'b0;
        endcase
    end

    always_comb begin
        w_push = 1'b0;
        w_err  = 1'b0;
        if (w_act) begin
            case (r_state)
                S_OP:
                    w_err = !(w_op_r || w_op_w || w_nl || w_ws);
                S_GAP:
                    w_err = !(w_ws || w_is_hex);
                S_ADDR:
                    if (w_is_hex) begin
                        w_err = (r_ndig == ND_MAX);
                    end else if (w_x0) begin
                        w_err = 1'b0;
                    end else if (w_nl) begin
                        w_push = (r_ndig != '0);
                        w_err  = (r_ndig == '0);
                    end else begin
                        w_err = !w_ws;
                    end
                S_TAIL: begin
                    w_push = w_nl;
                    w_err  = !(w_nl || w_ws);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_OP;
            r_op      <= 1'b0;
            r_acc     <= '0;
            r_ndig    <= '0;
            r_err_cnt <= '0;
        end else if (w_act) begin
            if (w_err && (r_err_cnt != 16'hFFFF))
                r_err_cnt <= r_err_cnt + 16'd1;
            case (r_state)
                S_OP:
                    if (w_op_r || w_op_w) begin
                        r_op    <= w_op_w;
                        r_state <= S_GAP;
                    end else if (w_err) begin
                        r_state <= S_SKIP;
                    end
                S_GAP:
                    if (w_is_hex) begin
                        r_acc   <= ADDR_W'(w_hex);
                        r_ndig  <= ND_W'(1);
                        r_state <= S_ADDR;
                    end else if (w_nl) begin
                        r_state <= S_OP;
                    end else if (w_err) begin
                        r_state <= S_SKIP;
                    end
                S_ADDR:
                    if (w_is_hex) begin
                        if (w_err) begin
                            r_state <= S_SKIP;
                        end else begin
                            r_acc  <= {r_acc[ADDR_W-5:0], w_hex};
                            r_ndig <= r_ndig + ND_W'(1);
                        end
                    end else if (w_x0) begin
                        r_acc  <= '0;
                        r_ndig <= '0;
                    end else if (w_nl) begin
                        r_state <= S_OP;
                    end else if (w_ws) begin
                        r_state <= S_TAIL;
                    end else begin
                        r_state <= S_SKIP;
                    end
                S_TAIL:
                    if (w_nl)
                        r_state <= S_OP;
                    else if (!w_ws)
                        r_state <= S_SKIP;
                S_SKIP:
                    if (w_nl)
                        r_state <= S_OP;
                default:
                    r_state <= S_OP;
            endcase
        end
    end

    assign w_empty  = (r_wptr == r_rptr);
    assign w_full   = (r_wptr[FIFO_AW] != r_rptr[FIFO_AW])
                   && (r_wptr[FIFO_AW-1:0] == r_rptr[FIFO_AW-1:0]);
    assign w_pop    = !w_empty && m_rec.ready;
    // a full FIFO still takes the record if the head leaves this cycle
    assign w_accept = w_push && (!w_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (w_accept)
            r_mem[r_wptr[FIFO_AW-1:0]] <= {r_op, r_acc};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_rec_cnt  <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wptr    <= r_wptr + 1'b1;
                r_rec_cnt <= r_rec_cnt + 32'd1;
            end
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_accept)
                r_overflow <= 1'b1;
        end
    end

    assign w_head = w_empty ? '0 : r_mem[r_rptr[FIFO_AW-1:0]];

    assign m_rec.valid = !w_empty;
    assign m_rec.we    = w_head[ADDR_W];
    assign m_rec.addr  = w_head[ADDR_W-1:0];
    assign o_overflow  = r_overflow;
    assign o_rec_count = r_rec_cnt;
    assign o_err_count = r_err_cnt;
endmodule
